// File: rtl/rbzero_pkg.sv
// rbzero_pkg: types and constants shared by the rbzero vector SPI loader.
//   vec_spi_state_t : loader FSM state (idle, SCLK low half, SCLK high half,
//                     inter-frame gap). The S_ prefix keeps the state names
//                     apart from the loader's GAP parameter.
//   VEC_FRAME_BITS  : default frame size, 6 words x 15 bits.
package rbzero_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_GAP
    } vec_spi_state_t;

    localparam int VEC_WORDS      = 6;
    localparam int VEC_WORD_W     = 15;
    localparam int VEC_FRAME_BITS = VEC_WORDS * VEC_WORD_W;

endpackage

// File: rtl/spi_half_period_ctr.sv
// spi_half_period_ctr: loadable down-counter timing one dwell period.
// Load with N-1 on entry to a state; tc goes high on the Nth clock in it.
//   clk, reset_n : clock, async active-low reset
//   load         : load load_val this clock (wins over counting)
//   load_val     : dwell length minus one
//   tc           : terminal count (counter at zero)
module spi_half_period_ctr #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        cnt <= '0;
        else if (load)       cnt <= load_val;
        else if (cnt != '0)  cnt <= cnt - 1'b1;
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/vec_spi_loader.sv
// vec_spi_loader: SPI mode-0 master that sends one full frame of view
// vectors (playerX..vplaneY, MSB first) to the rbzero vector slave.
//   clk, reset_n : clock, async active-low reset
//   i_data       : payload, word 0 in the top WORD_W bits
//   i_start      : frame request, honoured only when idle
//   i_vsync_n    : vsync, used only when VEC_SPI_AUTOSEND_EN is defined
//   o_busy       : frame in progress (accepted start through done)
//   o_done       : one-clock pulse at the end of the inter-frame gap
//   o_csb, o_sclk, o_mosi : SPI pins, all registered
// Optional feature macro: VEC_SPI_AUTOSEND_EN (send on vsync fall when the
// payload changed since the last capture).
module vec_spi_loader
    import rbzero_pkg::*;
#(
    parameter int WORDS  = VEC_WORDS,
    parameter int WORD_W = VEC_WORD_W,
    parameter int DIV    = 2,
    parameter int GAP    = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [WORDS*WORD_W-1:0] i_data,
    input  logic                    i_start,
    input  logic                    i_vsync_n,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_csb,
    output logic                    o_sclk,
    output logic                    o_mosi
);

    localparam int FRAME_BITS = WORDS * WORD_W;
    localparam int BIT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int CTR_W      = $clog2(((DIV > GAP) ? DIV : GAP) + 1);
    localparam logic [CTR_W-1:0] DIV_LD = CTR_W'(DIV - 1);
    localparam logic [CTR_W-1:0] GAP_LD = CTR_W'(GAP - 1);
    localparam logic [BIT_W-1:0] BIT_LD = BIT_W'(FRAME_BITS - 1);

    vec_spi_state_t        state, state_nxt;
    logic [FRAME_BITS-1:0] shreg;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  ctr_load, ctr_tc;
    logic [CTR_W-1:0]      ctr_val;
    logic                  capture, shift, start_req;

`ifdef VEC_SPI_AUTOSEND_EN
    logic [FRAME_BITS-1:0] last_data;
    logic                  dirty, vs_meta, vs_sync, vs_prev;

    // Sync flops reset high so releasing reset never looks like a vsync fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_data <= '0;
            dirty     <= 1'b0;
            vs_meta   <= 1'b1;
            vs_sync   <= 1'b1;
            vs_prev   <= 1'b1;
        end else begin
            vs_meta <= i_vsync_n;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
            if (capture) begin
                last_data <= i_data;
                dirty     <= 1'b0;
            end else if (i_data != last_data) begin
                dirty <= 1'b1;
            end
        end
    end

    // OR-ing the two sources means a coincident start sends a single frame.
    assign start_req = i_start | (dirty & vs_prev & ~vs_sync);
`else
    logic unused_vsync;
    assign unused_vsync = i_vsync_n;
    assign start_req    = i_start;
`endif

    spi_half_period_ctr #(.W(CTR_W)) u_ctr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (ctr_load),
        .load_val (ctr_val),
        .tc       (ctr_tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // o_busy stays set through the done cycle, so the first IDLE cycle after
    // a gap is a settle cycle and a held i_start re-triggers one clock later.
    always_comb begin
        state_nxt = state;
        ctr_load  = 1'b0;
        ctr_val   = DIV_LD;
        capture   = 1'b0;
        shift     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_req && !o_busy) begin
                    capture   = 1'b1;
                    ctr_load  = 1'b1;
                    state_nxt = S_LOW;
                end
            end
            S_LOW: begin
                if (ctr_tc) begin
                    ctr_load  = 1'b1;
                    state_nxt = S_HIGH;
                end
            end
            S_HIGH: begin
                if (ctr_tc) begin
                    ctr_load = 1'b1;
                    if (bit_cnt != '0) begin
                        shift     = 1'b1;
                        state_nxt = S_LOW;
                    end else begin
                        ctr_val   = GAP_LD;
                        state_nxt = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (ctr_tc) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (capture) begin
            shreg   <= i_data;
            bit_cnt <= BIT_LD;
        end else if (shift) begin
            shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
            bit_cnt <= bit_cnt - 1'b1;
        end
    end

    // Pins follow the current state one clock later; the shift happens on the
    // HIGH->LOW edge, so MOSI holds its bit through the whole LOW+HIGH pair.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_csb  <= 1'b1;
            o_sclk <= 1'b0;
            o_mosi <= 1'b0;
            o_done <= 1'b0;
            o_busy <= 1'b0;
        end else begin
            o_csb  <= !(state == S_LOW || state == S_HIGH);
            o_sclk <= (state == S_HIGH);
            o_mosi <= (state == S_LOW || state == S_HIGH) ? shreg[FRAME_BITS-1] : 1'b0;
            o_done <= (state == S_GAP) && ctr_tc;
            if (capture)     o_busy <= 1'b1;
            else if (o_done) o_busy <= 1'b0;
        end
    end

endmodule
